sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/mem_pkg.sv | 85 ++++++++
 rtl/load_align.sv | 13 +
 rtl/sram_ctrl.sv | 131 +++++++++++++
 tb/tb_sram_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-op codes, controller state encoding and the byte-lane helpers
// used by the SRAM controller, the MMU and the execute stage.
package mem_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LB  = 4'd1,
        OP_LBU = 4'd2,
        OP_LH  = 4'd3,
        OP_LHU = 4'd4,
        OP_LW  = 4'd5,
        OP_SB  = 4'd6,
        OP_SH  = 4'd7,
        OP_SW  = 4'd8
    } mem_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_e;

    // Codes 9..15 fall outside this range and behave as NOP.
    function automatic logic op_valid(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] offs);
        logic mis;
        mis = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: mis = offs[0];
            OP_LW, OP_SW:         mis = |offs;
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Active-low lane enables; loads read the whole word.
    function automatic logic [3:0] store_be_n(input logic [3:0] op, input logic [1:0] offs);
        logic [3:0] be_n;
        be_n = 4'b0000;
        case (op)
            OP_SB:   be_n = ~(4'b0001 << offs);
            OP_SH:   be_n = offs[1] ? 4'b0011 : 4'b1100;
            default: be_n = 4'b0000;
        endcase
        return be_n;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [3:0] op, input logic [31:0] data);
        logic [31:0] lanes;
        lanes = data;
        case (op)
            OP_SB:   lanes = {4{data[7:0]}};
            OP_SH:   lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [1:0] offs,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{offs, 3'b000} +: 8];
        h = offs[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   res = {{24{b[7]}}, b};
            OP_LBU:  res = {24'h000000, b};
            OP_LH:   res = {{16{h[15]}}, h};
            OP_LHU:  res = {16'h0000, h};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational read-lane select and sign/zero extension of a raw SRAM word.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [3:0]  op_i,
    input  logic [1:0]  offs_i,
    output logic [31:0] data_o
);

    assign data_o = load_extend(op_i, offs_i, word_i);

endmodule

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: one access per MMU request, SETUP/STROBE/HOLD
// bus phases with registered strobes, and a registered load result.
module sram_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  memOp_i,
    input  logic [19:0] physicalAddr_i,
    input  logic [31:0] storeData_i,
    output logic [31:0] ramData_o,
    output logic        stall_o,
    output logic        addrErr_o,
    output logic [19:0] sramAddr_o,
    inout  wire  [31:0] sramData_io,
    output logic        sramCe_n_o,
    output logic        sramOe_n_o,
    output logic        sramWe_n_o,
    output logic [3:0]  sramBe_n_o
);

    localparam logic [3:0] LAST_STROBE = 4'(WAIT_CYCLES - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  op_q;
    logic [19:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;
    logic [3:0]  be_n_q;
    logic        ce_n_q;
    logic        oe_n_q;
    logic        we_n_q;
    logic        drive_q;

    logic in_valid;
    logic in_mis;
    logic idle;
    logic accept;

    assign in_valid = op_valid(memOp_i);
    assign in_mis   = op_misaligned(memOp_i, physicalAddr_i[1:0]);
    assign idle     = (state_q == ST_IDLE);
    assign accept   = idle && in_valid && !in_mis;

    assign stall_o   = !rst && (accept || (state_q == ST_SETUP) ||
                                (state_q == ST_STROBE) || (state_q == ST_HOLD));
    assign addrErr_o = !rst && idle && in_valid && in_mis;

    assign sramAddr_o  = {2'b00, addr_q[19:2]};
    assign sramCe_n_o  = ce_n_q;
    assign sramOe_n_o  = oe_n_q;
    assign sramWe_n_o  = we_n_q;
    assign sramBe_n_o  = be_n_q;
    assign ramData_o   = rdata_q;
    assign sramData_io = drive_q ? wdata_q : 'z;

    load_align u_load_align (
        .word_i (sramData_io),
        .op_i   (op_q),
        .offs_i (addr_q[1:0]),
        .data_o (rdata_d)
    );

    // Strobe registers are loaded with the values of the state being entered,
    // so every bus pin changes exactly on the state edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_n_q  <= '1;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            drive_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_SETUP;
                        op_q    <= memOp_i;
                        addr_q  <= physicalAddr_i;
                        wdata_q <= store_lanes(memOp_i, storeData_i);
                        be_n_q  <= store_be_n(memOp_i, physicalAddr_i[1:0]);
                        ce_n_q  <= 1'b0;
                        oe_n_q  <= op_is_store(memOp_i);
                        drive_q <= op_is_store(memOp_i);
                    end
                end
                ST_SETUP: begin
                    state_q <= ST_STROBE;
                    cnt_q   <= '0;
                    we_n_q  <= !op_is_store(op_q);
                end
                ST_STROBE: begin
                    if (cnt_q == LAST_STROBE) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= '0;
                        we_n_q  <= 1'b1;
                        if (!op_is_store(op_q)) begin
                            rdata_q <= rdata_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_HOLD: begin
                    state_q <= ST_DONE;
                    ce_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    drive_q <= 1'b0;
                    be_n_q  <= '1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural SRAM: vector table on a
// WAIT_CYCLES=2 instance, plus back-to-back monitors on WAIT_CYCLES=1 and 4.
module tb_sram_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  memOp = OP_NOP;
    logic [19:0] pAddr = '0;
    logic [31:0] sData = '0;
    logic        b2b_en = 1'b0;

    logic [31:0] ram_data;
    logic        stall, addr_err, ce_n, oe_n, we_n;
    logic [19:0] sram_addr;
    logic [3:0]  be_n;
    wire  [31:0] sram_bus;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_ctrl #(.WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .memOp_i(memOp), .physicalAddr_i(pAddr), .storeData_i(sData),
        .ramData_o(ram_data), .stall_o(stall), .addrErr_o(addr_err), .sramAddr_o(sram_addr),
        .sramData_io(sram_bus), .sramCe_n_o(ce_n), .sramOe_n_o(oe_n), .sramWe_n_o(we_n),
        .sramBe_n_o(be_n)
    );

    // SRAM model: drives on read, commits a write when WE rises while CE is still low.
    logic [31:0] mem [0:255];
    logic        pend = 1'b0;
    logic [31:0] pdat;
    logic [3:0]  pbe;
    logic [7:0]  pidx;

    assign sram_bus = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 'z;

    always @(negedge clk) begin
        if (!ce_n && !we_n) begin
            pend = 1'b1;
            pdat = sram_bus;
            pbe  = be_n;
            pidx = sram_addr[7:0];
        end else begin
            if (pend && !ce_n)
                for (int i = 0; i < 4; i++)
                    if (!pbe[i]) mem[pidx][8*i +: 8] = pdat[8*i +: 8];
            pend = 1'b0;
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_b2b
        localparam int W = (k == 0) ? 1 : 4;
        wire  [31:0] bus;
        logic [31:0] rd;
        logic        st, ae, ce, oe, we;
        logic [19:0] sa;
        logic [3:0]  be;
        logic [31:0] m [0:15];
        logic        mp = 1'b0;
        logic [31:0] md;
        logic [3:0]  mbe;
        logic [3:0]  midx;
        int we_run = 0, ce_run = 0, st_run = 0, gap = 0, gap_st = 0, runs = 0;
        int we_bad = 0, gap_bad = 0, len_bad = 0, oe_bad = 0;
        bit seen = 1'b0;

        sram_ctrl #(.WAIT_CYCLES(W)) u_dut (
            .clk(clk), .rst(rst), .memOp_i(memOp), .physicalAddr_i(pAddr), .storeData_i(sData),
            .ramData_o(rd), .stall_o(st), .addrErr_o(ae), .sramAddr_o(sa),
            .sramData_io(bus), .sramCe_n_o(ce), .sramOe_n_o(oe), .sramWe_n_o(we),
            .sramBe_n_o(be)
        );

        assign bus = (!ce && !oe && we) ? m[sa[3:0]] : 'z;

        always @(negedge clk) begin
            if (!ce && !we) begin
                mp = 1'b1; md = bus; mbe = be; midx = sa[3:0];
            end else begin
                if (mp && !ce)
                    for (int i = 0; i < 4; i++)
                        if (!mbe[i]) m[midx][8*i +: 8] = md[8*i +: 8];
                mp = 1'b0;
            end
        end

        always @(negedge clk) begin
            #2;
            if (b2b_en) begin
                if (!oe && !we) oe_bad++;
                if (!we) we_run++;
                else if (we_run != 0) begin
                    if (we_run != W) we_bad++;
                    we_run = 0;
                    runs++;
                end
                if (ce) begin
                    if (ce_run != 0 && ce_run != W + 2) len_bad++;
                    ce_run = 0;
                    gap++;
                    if (st) gap_st++;
                end else begin
                    if (seen && gap != 0 && (gap != 2 || gap_st != 1)) gap_bad++;
                    gap = 0;
                    gap_st = 0;
                    seen = 1'b1;
                    ce_run++;
                end
                if (st) st_run++;
                else begin
                    if (st_run != 0 && st_run != W + 3) len_bad++;
                    st_run = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int          r_st, r_we, r_oe;
    logic [3:0]  r_be;
    logic [19:0] r_sa;
    bit          r_done;

    // Presents one op and follows it to DONE; an op presented during DONE just waits.
    task automatic run_op(input logic [3:0] op, input logic [19:0] addr, input logic [31:0] wd);
        r_st = 0; r_we = 0; r_oe = 0; r_be = '1; r_sa = '0; r_done = 1'b0;
        memOp = op; pAddr = addr; sData = wd;
        for (int c = 0; c < 40 && !r_done; c++) begin
            #1;
            if (stall) r_st++;
            if (!we_n) r_we++;
            if (!oe_n) r_oe++;
            if (!ce_n) begin r_be = be_n; r_sa = sram_addr; end
            if (!stall && r_st > 0) r_done = 1'b1;
            else @(negedge clk);
        end
        memOp = OP_NOP;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [19:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [3:0]  exp_be;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs = '{
            '{OP_SW,  20'h00000, 32'h0BADF00D, 32'h00000000, 4'b0000},
            '{OP_SW,  20'h00030, 32'h01020304, 32'h00000000, 4'b0000},
            '{OP_SW,  20'h00010, 32'hDEADBEEF, 32'h00000000, 4'b0000},
            '{OP_LW,  20'h00010, 32'h00000000, 32'hDEADBEEF, 4'b0000},
            '{OP_SW,  20'h00010, 32'h11223344, 32'hDEADBEEF, 4'b0000},
            '{OP_SB,  20'h00013, 32'h000000A5, 32'hDEADBEEF, 4'b0111},
            '{OP_LW,  20'h00010, 32'h00000000, 32'hA5223344, 4'b0000},
            '{OP_LB,  20'h00013, 32'h00000000, 32'hFFFFFFA5, 4'b0000},
            '{OP_LBU, 20'h00013, 32'h00000000, 32'h000000A5, 4'b0000},
            '{OP_SW,  20'h00020, 32'h80017FFF, 32'h000000A5, 4'b0000},
            '{OP_LH,  20'h00022, 32'h00000000, 32'hFFFF8001, 4'b0000},
            '{OP_LHU, 20'h00022, 32'h00000000, 32'h00008001, 4'b0000},
            '{OP_LH,  20'h00020, 32'h00000000, 32'h00007FFF, 4'b0000},
            '{OP_LB,  20'h00020, 32'h00000000, 32'hFFFFFFFF, 4'b0000},
            '{OP_LB,  20'h00021, 32'h00000000, 32'h0000007F, 4'b0000},
            '{OP_LBU, 20'h00022, 32'h00000000, 32'h00000001, 4'b0000},
            '{OP_SH,  20'h00022, 32'hABCD1234, 32'h00000001, 4'b0011},
            '{OP_LW,  20'h00020, 32'h00000000, 32'h12347FFF, 4'b0000},
            '{OP_SH,  20'h00020, 32'h0000BEEF, 32'h12347FFF, 4'b1100},
            '{OP_SB,  20'h00020, 32'hFFFFFF5A, 32'h12347FFF, 4'b1110},
            '{OP_SB,  20'h00021, 32'h00000066, 32'h12347FFF, 4'b1101},
            '{OP_LW,  20'h00020, 32'h00000000, 32'h1234665A, 4'b0000},
            '{OP_LHU, 20'h00022, 32'h00000000, 32'h00001234, 4'b0000},
            '{OP_LB,  20'h00011, 32'h00000000, 32'h00000033, 4'b0000}
        };

        // Reset with a valid op on the inputs: stall must stay low.
        memOp = OP_LW;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_addrerr", {31'd0, addr_err}, 32'd0);
        check("rst_strobes", {29'd0, ce_n, oe_n, we_n}, 32'd7);
        check("rst_be", {28'd0, be_n}, 32'hF);
        check("rst_rdata", ram_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        memOp = OP_NOP;
        @(negedge clk);

        for (int v = 0; v < NV; v++) begin
            run_op(vecs[v].op, vecs[v].addr, vecs[v].wd);
            check($sformatf("v%0d_done", v), {31'd0, r_done}, 32'd1);
            check($sformatf("v%0d_stall_cycles", v), r_st, 32'd5);
            check($sformatf("v%0d_be", v), {28'd0, r_be}, {28'd0, vecs[v].exp_be});
            check($sformatf("v%0d_sram_addr", v), {12'd0, r_sa}, {14'd0, vecs[v].addr[19:2]});
            check($sformatf("v%0d_we_cycles", v), r_we, op_is_store(vecs[v].op) ? 32'd2 : 32'd0);
            check($sformatf("v%0d_oe_cycles", v), r_oe, op_is_store(vecs[v].op) ? 32'd0 : 32'd4);
            check($sformatf("v%0d_rdata", v), ram_data, vecs[v].exp_rd);
        end

        // Unused op code behaves as NOP.
        @(negedge clk);
        memOp = 4'd9; pAddr = 20'h00010;
        repeat (2) begin
            #1;
            check("nop9_stall", {31'd0, stall}, 32'd0);
            check("nop9_ce", {31'd0, ce_n}, 32'd1);
            check("nop9_addrerr", {31'd0, addr_err}, 32'd0);
            @(negedge clk);
        end

        // Misaligned LW then SH: flagged, no stall, no bus cycle, memory untouched.
        memOp = OP_LW; pAddr = 20'h00002; sData = 32'h12345678;
        repeat (2) begin
            #1;
            check("misLW_addrerr", {31'd0, addr_err}, 32'd1);
            check("misLW_stall", {31'd0, stall}, 32'd0);
            check("misLW_ce", {31'd0, ce_n}, 32'd1);
            @(negedge clk);
        end
        memOp = OP_SH; pAddr = 20'h00001; sData = 32'h0000FFFF;
        repeat (2) begin
            #1;
            check("misSH_addrerr", {31'd0, addr_err}, 32'd1);
            check("misSH_stall", {31'd0, stall}, 32'd0);
            check("misSH_ce", {31'd0, ce_n}, 32'd1);
            @(negedge clk);
        end
        memOp = OP_NOP;
        #1;
        check("mis_clear_addrerr", {31'd0, addr_err}, 32'd0);
        check("mis_mem_word0", mem[0], 32'h0BADF00D);
        run_op(OP_LW, 20'h00000, 32'd0);
        check("mis_reload_word0", ram_data, 32'h0BADF00D);

        // Reset in the first STROBE cycle of a store.
        @(negedge clk);
        r_done = 1'b0;
        memOp = OP_SW; pAddr = 20'h00030; sData = 32'hCAFEF00D;
        for (int c = 0; c < 10 && !r_done; c++) begin
            #1;
            if (!we_n) r_done = 1'b1;
            else @(negedge clk);
        end
        check("rstw_found_strobe", {31'd0, r_done}, 32'd1);
        rst = 1'b1;
        memOp = OP_NOP;
        #1;
        check("rstw_stall_in_rst", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        check("rstw_strobes", {29'd0, ce_n, oe_n, we_n}, 32'd7);
        check("rstw_be", {28'd0, be_n}, 32'hF);
        check("rstw_stall", {31'd0, stall}, 32'd0);
        check("rstw_rdata", ram_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rstw_mem_intact", mem[12], 32'h01020304);
        run_op(OP_LW, 20'h00030, 32'd0);
        check("rstw_reload", ram_data, 32'h01020304);

        // Back-to-back SW then LW held on the inputs, WAIT_CYCLES=1 and 4.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        memOp = OP_SW; pAddr = 20'h00008; sData = 32'h5EED1234;
        b2b_en = 1'b1;
        repeat (30) @(negedge clk);
        memOp = OP_LW;
        repeat (30) @(negedge clk);
        b2b_en = 1'b0;
        memOp = OP_NOP;
        repeat (10) @(negedge clk);
        check("b2b_w1_rdata", g_b2b[0].rd, 32'h5EED1234);
        check("b2b_w1_runs", {31'd0, g_b2b[0].runs >= 2}, 32'd1);
        check("b2b_w1_we_len", g_b2b[0].we_bad, 32'd0);
        check("b2b_w1_gap", g_b2b[0].gap_bad, 32'd0);
        check("b2b_w1_len", g_b2b[0].len_bad, 32'd0);
        check("b2b_w1_oe_we", g_b2b[0].oe_bad, 32'd0);
        check("b2b_w4_rdata", g_b2b[1].rd, 32'h5EED1234);
        check("b2b_w4_runs", {31'd0, g_b2b[1].runs >= 2}, 32'd1);
        check("b2b_w4_we_len", g_b2b[1].we_bad, 32'd0);
        check("b2b_w4_gap", g_b2b[1].gap_bad, 32'd0);
        check("b2b_w4_len", g_b2b[1].len_bad, 32'd0);
        check("b2b_w4_oe_we", g_b2b[1].oe_bad, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
